// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel programmable clock divider.
// Holds the channel state enum, the minimum legal divisor and the high-time clamp.
package clk_div_pkg;

   localparam int MIN_DIV = 2;
   localparam int MAX_W   = 64;

   typedef enum logic {
      DISABLED = 1'b0,
      RUN      = 1'b1
   } ch_state_e;

   // Caller guarantees div >= MIN_DIV, so div-1 is always a legal high-time.
   function automatic logic [MAX_W-1:0] clamp_high(input logic [MAX_W-1:0] div,
                                                   input logic [MAX_W-1:0] high);
      logic [MAX_W-1:0] res;
      if (high >= div) begin
         res = div - MAX_W'(1);
      end else if (high == '0) begin
         res = MAX_W'(1);
      end else begin
         res = high;
      end
      return res;
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, shadow/active divisor and high-time, registered outputs.
// Outputs lag the counter by one cycle; no backpressure, loads are always sampled.
module clk_div_channel
   import clk_div_pkg::*;
#(
   parameter int          WIDTH        = 28,
   parameter int unsigned DEFAULT_DIV  = 32000,
   parameter int unsigned DEFAULT_HIGH = DEFAULT_DIV / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ch_en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   input  logic [WIDTH-1:0] high_in,
   output logic             clk_out,
   output logic             tick,
   output logic             pending,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_HIGH);

   ch_state_e        state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] act_div_q, act_div_d;
   logic [WIDTH-1:0] act_high_q, act_high_d;
   logic [WIDTH-1:0] sh_div_q, sh_div_d;
   logic [WIDTH-1:0] sh_high_q, sh_high_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic             load_err_q, load_err_d;

   logic             load_ok;
   logic             at_boundary;
   logic             direct;
   logic [WIDTH-1:0] high_val;

   always_comb begin
      load_ok     = load && (div_in >= WIDTH'(MIN_DIV));
      high_val    = WIDTH'(clamp_high(MAX_W'(div_in), MAX_W'(high_in)));
      at_boundary = (state_q == RUN) && ch_en && (cnt_q == act_div_q - WIDTH'(1));
      // Active may be rewritten whenever no period is in flight or one is just ending.
      direct      = !ch_en || (state_q == DISABLED) || at_boundary;

      sh_div_d    = load_ok ? div_in   : sh_div_q;
      sh_high_d   = load_ok ? high_val : sh_high_q;
      load_err_d  = load && !load_ok;

      act_div_d   = act_div_q;
      act_high_d  = act_high_q;
      pend_d      = pend_q | load_ok;
      if (direct) begin
         act_div_d  = sh_div_d;
         act_high_d = sh_high_d;
         pend_d     = 1'b0;
      end

      state_d   = state_q;
      cnt_d     = '0;
      clk_out_d = 1'b0;
      tick_d    = 1'b0;
      case (state_q)
         DISABLED: begin
            if (ch_en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!ch_en) begin
               state_d = DISABLED;
            end else begin
               cnt_d     = at_boundary ? '0 : cnt_q + WIDTH'(1);
               clk_out_d = (cnt_q < act_high_q);
               tick_d    = (cnt_q == '0);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= DISABLED;
         cnt_q      <= '0;
         act_div_q  <= DEF_DIV;
         act_high_q <= DEF_HIGH;
         sh_div_q   <= DEF_DIV;
         sh_high_q  <= DEF_HIGH;
         pend_q     <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         act_div_q  <= act_div_d;
         act_high_q <= act_high_d;
         sh_div_q   <= sh_div_d;
         sh_high_q  <= sh_high_d;
         pend_q     <= pend_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
         load_err_q <= load_err_d;
      end
   end

   assign clk_out  = clk_out_q;
   assign tick     = tick_q;
   assign pending  = pend_q;
   assign load_err = load_err_q;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel run-time programmable clock divider; one independent channel per bit.
// Outputs registered one cycle after the counter; no backpressure on loads.
module clk_divider_multi
   import clk_div_pkg::*;
#(
   parameter int          WIDTH        = 28,
   parameter int          NUM_CH       = 2,
   parameter int unsigned DEFAULT_DIV  = 32000,
   parameter int unsigned DEFAULT_HIGH = DEFAULT_DIV / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] load,
   input  logic [WIDTH-1:0]  div_in,
   input  logic [WIDTH-1:0]  high_in,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] load_err
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_channel #(
         .WIDTH        (WIDTH),
         .DEFAULT_DIV  (DEFAULT_DIV),
         .DEFAULT_HIGH (DEFAULT_HIGH)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .ch_en    (ch_en[i]),
         .load     (load[i]),
         .div_in   (div_in),
         .high_in  (high_in),
         .clk_out  (clk_out[i]),
         .tick     (tick[i]),
         .pending  (pending[i]),
         .load_err (load_err[i])
      );
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed bench for clk_divider_multi with DEFAULT_DIV=8, DEFAULT_HIGH=4, two channels.
module tb_clk_divider_multi;

   localparam int W   = 28;
   localparam int NCH = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] ch_en = '0;
   logic [NCH-1:0] load = '0;
   logic [W-1:0]   div_in = '0;
   logic [W-1:0]   high_in = '0;
   logic [NCH-1:0] clk_out, tick, pending, load_err;

   int n_cmp = 0;
   int n_bad = 0;

   clk_divider_multi #(
      .WIDTH        (W),
      .NUM_CH       (NCH),
      .DEFAULT_DIV  (8),
      .DEFAULT_HIGH (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ch_en    (ch_en),
      .load     (load),
      .div_in   (div_in),
      .high_in  (high_in),
      .clk_out  (clk_out),
      .tick     (tick),
      .pending  (pending),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({clk_out, tick, pending, load_err} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_outputs got %b exp 00000000", {clk_out, tick, pending, load_err});
      end
      step();
      step();
      n_cmp++;
      if ({clk_out, tick, pending, load_err} !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_held got %b exp 00000000", {clk_out, tick, pending, load_err});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_default_wave();
      logic [1:0] ec, et;
      ch_en = 2'b01;
      step();
      n_cmp++;
      if ({clk_out, tick} !== 4'b0000) begin
         n_bad++;
         $display("FAIL arm_cycle got clk_out=%b tick=%b exp 00/00", clk_out, tick);
      end
      for (int k = 0; k < 16; k++) begin
         step();
         ec = {1'b0, (k % 8) < 4};
         et = {1'b0, (k % 8) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== et || pending !== 2'b00) begin
            n_bad++;
            $display("FAIL default_wave k=%0d got clk_out=%b tick=%b pend=%b exp %b %b 00",
                     k, clk_out, tick, pending, ec, et);
         end
      end
   endtask

   task automatic test_load_pending();
      logic [1:0] ec, et, ep;
      step();
      step();
      load = 2'b01; div_in = 5; high_in = 2;
      step();
      load = 2'b00;
      n_cmp++;
      if (pending !== 2'b01 || clk_out !== 2'b01) begin
         n_bad++;
         $display("FAIL load_accept got pend=%b clk_out=%b exp 01 01", pending, clk_out);
      end
      for (int c = 3; c < 8; c++) begin
         step();
         ep = {1'b0, c != 7};
         ec = {1'b0, c < 4};
         n_cmp++;
         if (pending !== ep || clk_out !== ec) begin
            n_bad++;
            $display("FAIL pending_hold c=%0d got pend=%b clk_out=%b exp %b %b",
                     c, pending, clk_out, ep, ec);
         end
      end
      for (int k = 0; k < 10; k++) begin
         step();
         ec = {1'b0, (k % 5) < 2};
         et = {1'b0, (k % 5) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== et || pending !== 2'b00) begin
            n_bad++;
            $display("FAIL div5_wave k=%0d got clk_out=%b tick=%b pend=%b exp %b %b 00",
                     k, clk_out, tick, pending, ec, et);
         end
      end
   endtask

   task automatic test_load_err();
      logic [1:0] ec, et, ep;
      load = 2'b01; div_in = 1; high_in = 0;
      step();
      load = 2'b00;
      n_cmp++;
      if (load_err !== 2'b01 || pending !== 2'b00 || clk_out !== 2'b01 || tick !== 2'b01) begin
         n_bad++;
         $display("FAIL reject_div1 got err=%b pend=%b clk_out=%b tick=%b exp 01 00 01 01",
                  load_err, pending, clk_out, tick);
      end
      for (int c = 1; c < 5; c++) begin
         step();
         ec = {1'b0, c < 2};
         n_cmp++;
         if (load_err !== 2'b00 || clk_out !== ec || pending !== 2'b00) begin
            n_bad++;
            $display("FAIL after_reject c=%0d got err=%b clk_out=%b pend=%b exp 00 %b 00",
                     c, load_err, clk_out, pending, ec);
         end
      end
      load = 2'b01; div_in = 6; high_in = 9;
      step();
      load = 2'b00;
      n_cmp++;
      if (load_err !== 2'b00 || pending !== 2'b01 || clk_out !== 2'b01) begin
         n_bad++;
         $display("FAIL clamp_accept got err=%b pend=%b clk_out=%b exp 00 01 01",
                  load_err, pending, clk_out);
      end
      for (int c = 1; c < 5; c++) begin
         step();
         ep = {1'b0, c != 4};
         ec = {1'b0, c < 2};
         n_cmp++;
         if (pending !== ep || clk_out !== ec || load_err !== 2'b00) begin
            n_bad++;
            $display("FAIL clamp_pending c=%0d got pend=%b clk_out=%b err=%b exp %b %b 00",
                     c, pending, clk_out, load_err, ep, ec);
         end
      end
      for (int k = 0; k < 12; k++) begin
         step();
         ec = {1'b0, (k % 6) < 5};
         et = {1'b0, (k % 6) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== et) begin
            n_bad++;
            $display("FAIL clamp_wave k=%0d got clk_out=%b tick=%b exp %b %b",
                     k, clk_out, tick, ec, et);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ec;
      for (int c = 0; c < 5; c++) step();
      load = 2'b01; div_in = 3; high_in = 1;
      step();
      load = 2'b00;
      n_cmp++;
      if (pending !== 2'b00 || clk_out !== 2'b00 || tick !== 2'b00) begin
         n_bad++;
         $display("FAIL bypass_edge got pend=%b clk_out=%b tick=%b exp 00 00 00",
                  pending, clk_out, tick);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         ec = {1'b0, (k % 3) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== ec || pending !== 2'b00) begin
            n_bad++;
            $display("FAIL bypass_wave k=%0d got clk_out=%b tick=%b pend=%b exp %b %b 00",
                     k, clk_out, tick, pending, ec, ec);
         end
      end
   endtask

   task automatic test_disable();
      logic [1:0] ec, et;
      load = 2'b01; div_in = 8; high_in = 6;
      step();
      load = 2'b00;
      step();
      step();
      n_cmp++;
      if (pending !== 2'b00) begin
         n_bad++;
         $display("FAIL div8_boundary got pend=%b exp 00", pending);
      end
      for (int c = 0; c < 3; c++) step();
      n_cmp++;
      if (clk_out !== 2'b01) begin
         n_bad++;
         $display("FAIL mid_high got clk_out=%b exp 01", clk_out);
      end
      ch_en = 2'b00;
      load = 2'b01; div_in = 4; high_in = 2;
      step();
      load = 2'b00;
      n_cmp++;
      if (clk_out !== 2'b00 || tick !== 2'b00 || pending !== 2'b00) begin
         n_bad++;
         $display("FAIL disable_edge got clk_out=%b tick=%b pend=%b exp 00 00 00",
                  clk_out, tick, pending);
      end
      step();
      step();
      ch_en = 2'b01;
      step();
      n_cmp++;
      if (clk_out !== 2'b00 || tick !== 2'b00) begin
         n_bad++;
         $display("FAIL rearm_cycle got clk_out=%b tick=%b exp 00 00", clk_out, tick);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         ec = {1'b0, (k % 4) < 2};
         et = {1'b0, (k % 4) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== et) begin
            n_bad++;
            $display("FAIL reenable_wave k=%0d got clk_out=%b tick=%b exp %b %b",
                     k, clk_out, tick, ec, et);
         end
      end
   endtask

   task automatic test_multi_channel();
      logic [1:0] ec, et;
      ch_en = 2'b00;
      step();
      load = 2'b11; div_in = 4; high_in = 2;
      step();
      load = 2'b10; div_in = 6; high_in = 3;
      step();
      load = 2'b00;
      ch_en = 2'b11;
      step();
      for (int k = 0; k < 12; k++) begin
         step();
         ec = {(k % 6) < 3, (k % 4) < 2};
         et = {(k % 6) == 0, (k % 4) == 0};
         n_cmp++;
         if (clk_out !== ec || tick !== et) begin
            n_bad++;
            $display("FAIL two_ch_wave k=%0d got clk_out=%b tick=%b exp %b %b",
                     k, clk_out, tick, ec, et);
         end
      end
      load = 2'b10; div_in = 6; high_in = 1;
      step();
      load = 2'b00;
      n_cmp++;
      if (pending !== 2'b10 || clk_out !== 2'b11 || tick !== 2'b11) begin
         n_bad++;
         $display("FAIL ch1_only_load got pend=%b clk_out=%b tick=%b exp 10 11 11",
                  pending, clk_out, tick);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({clk_out, tick, pending, load_err} !== 8'h00) begin
         n_bad++;
         $display("FAIL async_reset got %b exp 00000000", {clk_out, tick, pending, load_err});
      end
      #2;
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (clk_out !== 2'b00 || tick !== 2'b00) begin
         n_bad++;
         $display("FAIL post_reset_arm got clk_out=%b tick=%b exp 00 00", clk_out, tick);
      end
      for (int k = 0; k < 16; k++) begin
         step();
         ec = {2{(k % 8) < 4}};
         et = {2{(k % 8) == 0}};
         n_cmp++;
         if (clk_out !== ec || tick !== et || pending !== 2'b00) begin
            n_bad++;
            $display("FAIL defaults_restored k=%0d got clk_out=%b tick=%b pend=%b exp %b %b 00",
                     k, clk_out, tick, pending, ec, et);
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_wave();
      test_load_pending();
      test_load_err();
      test_back_to_back();
      test_disable();
      test_multi_channel();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clk_divider_multi.md
Name: clk_divider_multi

Overview:
- Multi-channel, run-time programmable clock divider.
- Each channel generates a divided clock with a programmable duty cycle, plus a one-cycle period-start tick.
- Divisor and high-time are reprogrammed glitch-free: new values take effect only at a period boundary.
- Sits beside the 32 kHz timebase and feeds the valve-timer and sensor-sampling logic. Each consumer gets its own rate, so a separate hard-coded divider per rate is no longer needed.

Parameters:
- WIDTH, 28, width of counter, divisor and high-time.
- NUM_CH, 2, number of independent divider channels.
- DEFAULT_DIV, 32000, divisor loaded at reset. Must be >= 2.
- DEFAULT_HIGH, DEFAULT_DIV/2, high-time loaded at reset. Must be in [1, DEFAULT_DIV-1].

Ports:
- clk  in  1  system clock (32 kHz timebase).
- rst_n  in  1  reset, asynchronous, active-low.
- ch_en  in  NUM_CH  per-channel run enable.
- load  in  NUM_CH  per-channel load strobe; one cycle samples div_in/high_in.
- div_in  in  WIDTH  requested divisor, shared by all channels.
- high_in  in  WIDTH  requested high-time in clk cycles, shared.
- clk_out  out  NUM_CH  divided clock, registered.
- tick  out  NUM_CH  one-cycle pulse, aligned with each clk_out rising edge.
- pending  out  NUM_CH  shadow values are waiting for a period boundary.
- load_err  out  NUM_CH  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - counter = 0.
  - active_div = shadow_div = DEFAULT_DIV.
  - active_high = shadow_high = DEFAULT_HIGH.
  - clk_out, tick, pending, load_err all = 0.
- Per-channel state: DISABLED and RUN.
- DISABLED (ch_en = 0):
  - counter held at 0; clk_out = 0, tick = 0.
  - Any pending shadow is copied to active immediately, then pending = 0.
- RUN (ch_en = 1):
  - Each edge: counter <= (counter == active_div-1) ? 0 : counter+1.
  - clk_out <= (counter < active_high).
  - tick <= (counter == 0).
  - Outputs lag the counter by one cycle. tick and the clk_out rising edge fall in the same cycle.
- DISABLED -> RUN: on the edge where ch_en is sampled high, counter starts at 0. On the next edge clk_out = 1 and tick = 1.
- RUN -> DISABLED: on the first edge with ch_en = 0, counter = 0 and clk_out = 0. No partial-period completion.
- Period: exactly active_div cycles. High phase: exactly active_high cycles.
- Load validation:
  - load with div_in < 2: rejected. Shadow unchanged; load_err pulses one cycle.
  - high_in = 0: clamped to 1.
  - high_in >= div_in: clamped to div_in-1.
  - A clamped load is accepted and does not raise load_err.
- Accepted load: shadow <= validated values; pending <= 1.
  - A second load while pending overwrites the shadow (last write wins).
- Boundary update: on the edge where counter == active_div-1 in RUN, active <= shadow and pending <= 0. The new period uses the new values from counter 0.
- Load in the same cycle as the boundary: the new load values go straight to active (bypass); pending stays 0.
- Load in the same cycle as disable: values go straight to active.
- Multiple load bits set in one cycle: each selected channel captures the same div_in/high_in.
- Channels are fully independent. No shared counter; no phase alignment between channels.
- Reset mid-operation: all state returns immediately to reset values, including shadow and pending.
- Arithmetic: all compares unsigned, WIDTH bits. The counter never exceeds active_div-1, so no wrap-around past 2^WIDTH-1.

Decomposition:
- Package clk_div_pkg holds:
  - MIN_DIV = 2.
  - the channel-state enum {DISABLED, RUN}.
  - a function returning the clamped high-time for a given (div, high) pair.
- Sub-module clk_div_channel contains one counter, its shadow/active registers and its output registers. It is instantiated NUM_CH times in a generate loop.
- The top level only fans out div_in/high_in and slices the per-channel vectors.

Test Plan:
- Reset with DEFAULT_DIV=8, DEFAULT_HIGH=4, ch_en=1 -> clk_out pattern 1111_0000 repeating; tick every 8 cycles, coincident with the rising edge; pending = 0.
- Load div=5, high=2 at counter=2 -> pending = 1 until counter = 7. The next period reads 11000 and pending clears on that edge.
- Load div=1 -> load_err pulses one cycle; waveform and pending unchanged. Load div=6, high=9 -> high clamps to 5, giving 111110; load_err stays 0.
- Load coincident with counter == active_div-1 (div=3, high=1) -> the following period is already 100, with no pending pulse.
- Deassert ch_en mid high phase -> clk_out = 0 on the next edge. Reassert -> the first tick and clk_out = 1 come 1 cycle after ch_en is sampled high.
- NUM_CH=2: ch0 div=4, ch1 div=6; load only ch1; assert rst_n=0 asynchronously mid-period -> ch0 is unaffected by the load; all outputs drop to 0 without a clock edge; defaults are restored.
